// File: rtl/ntt_pkg.sv
// Shared NTT definitions: mode encoding, sequencer states and
// the twiddle stage-base helper.
package ntt_pkg;

   localparam logic MODE_NTT  = 1'b0;
   localparam logic MODE_INTT = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } seq_state_t;

   // First twiddle index of stage s: 2^s - 1
   function automatic logic [31:0] tf_base(input logic [31:0] s);
      return (32'd1 << s) - 32'd1;
   endfunction

endpackage

// File: rtl/tf_lane_addr.sv
// Per-lane twiddle ROM address for stage s, beat c, lane index.
// Ports: s, c, lane, mode in; addr out (AW bits).
module tf_lane_addr
   import ntt_pkg::*;
#(
   parameter int LOGN  = 10,
   parameter int LANES = 1,
   parameter int AW    = LOGN,
   parameter int SW    = 4,
   parameter int CW    = 9,
   parameter int LW    = 1
) (
   input  logic [SW-1:0] s,
   input  logic [CW-1:0] c,
   input  logic [LW-1:0] lane,
   input  logic          mode,
   output logic [AW-1:0] addr
);

   logic [AW-1:0] b;
   logic [AW-1:0] sh;
   logic [AW-1:0] k;
   logic [AW-1:0] base;

   assign b    = AW'(c) * AW'(LANES) + AW'(lane);
   assign sh   = AW'(LOGN - 1) - AW'(s);
   assign k    = b >> sh;
   assign base = AW'(tf_base(32'(s)));

   // INTT walks each stage block backwards
   assign addr = (mode == MODE_INTT) ? (base << 1) - k
                                     : base + k;

endmodule

// File: rtl/tf_addr_seq.sv
// Self-sequencing twiddle address generator: walks all stages/beats.
// Ports: clk, rst, start, mode, tf_ready in; busy, done, tf_* out.
module tf_addr_seq
   import ntt_pkg::*;
#(
   parameter  int LOGN  = 10,
   parameter  int LANES = 1,
   parameter  int AW    = LOGN,
   localparam int SW    = (LOGN > 1) ? $clog2(LOGN) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                mode,
   output logic                busy,
   output logic                done,
   output logic                tf_valid,
   input  logic                tf_ready,
   output logic [LANES*AW-1:0] tf_addr,
   output logic [SW-1:0]       tf_stage,
   output logic                tf_last_in_stage
);

   localparam int NB = (1 << (LOGN - 1)) / LANES;
   localparam int CW = (NB > 1) ? $clog2(NB) : 1;
   localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [CW-1:0] C_LAST = CW'(NB - 1);
   localparam logic [SW-1:0] S_TOP  = SW'(LOGN - 1);

   seq_state_t state, state_n;

   logic          mode_q;
   logic          more_q;
   logic [SW-1:0] s_q;
   logic [CW-1:0] c_q;

   logic          starting;
   logic          load;
   logic          accept;
   logic          cur_mode;
   logic [SW-1:0] cur_s;
   logic [CW-1:0] cur_c;
   logic          last_beat;
   logic          final_beat;

   logic [LANES*AW-1:0] addr_n;

   // The first beat is issued straight from the start inputs so
   // tf_valid rises the cycle after start is accepted.
   assign starting = (state == IDLE) && start;
   assign cur_mode = starting ? mode : mode_q;
   assign cur_s    = starting ? ((mode == MODE_INTT) ? S_TOP : '0)
                              : s_q;
   assign cur_c    = starting ? '0 : c_q;

   assign accept = tf_valid && tf_ready;
   assign load   = starting ||
                   ((state == RUN) && more_q &&
                    (!tf_valid || tf_ready));

   assign last_beat  = (cur_c == C_LAST);
   assign final_beat = last_beat &&
                       (cur_s == ((cur_mode == MODE_INTT) ? '0 : S_TOP));

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      tf_lane_addr #(
         .LOGN  (LOGN),
         .LANES (LANES),
         .AW    (AW),
         .SW    (SW),
         .CW    (CW),
         .LW    (LW)
      ) u_lane (
         .s    (cur_s),
         .c    (cur_c),
         .lane (LW'(l)),
         .mode (cur_mode),
         .addr (addr_n[l*AW +: AW])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      busy    = 1'b0;
      done    = 1'b0;
      unique case (state)
         IDLE: if (start) state_n = RUN;
         RUN: begin
            busy = 1'b1;
            if (!more_q && accept) state_n = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q           <= MODE_NTT;
         more_q           <= 1'b0;
         s_q              <= '0;
         c_q              <= '0;
         tf_valid         <= 1'b0;
         tf_addr          <= '0;
         tf_stage         <= '0;
         tf_last_in_stage <= 1'b0;
      end else if (load) begin
         tf_valid         <= 1'b1;
         tf_addr          <= addr_n;
         tf_stage         <= cur_s;
         tf_last_in_stage <= last_beat;
         mode_q           <= cur_mode;
         more_q           <= !final_beat;
         c_q              <= last_beat ? '0 : cur_c + 1'b1;
         if (last_beat)
            s_q <= (cur_mode == MODE_INTT) ? cur_s - 1'b1
                                           : cur_s + 1'b1;
         else
            s_q <= cur_s;
      end else if (tf_ready) begin
         tf_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_tf_addr_seq.sv
// Bench for tf_addr_seq: LOGN=4 with one and two lanes against a
// beat-index model plus literal address tables.
module tb_tf_addr_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       start0;
   logic       start1;
   logic       mode;
   logic       tf_ready;

   logic       busy0, done0, valid0, last0;
   logic [3:0] addr0;
   logic [1:0] stg0;
   logic       busy1, done1, valid1, last1;
   logic [7:0] addr1;
   logic [1:0] stg1;

   tf_addr_seq #(.LOGN(4), .LANES(1)) u0 (
      .clk              (clk),
      .rst              (rst),
      .start            (start0),
      .mode             (mode),
      .busy             (busy0),
      .done             (done0),
      .tf_valid         (valid0),
      .tf_ready         (tf_ready),
      .tf_addr          (addr0),
      .tf_stage         (stg0),
      .tf_last_in_stage (last0)
   );

   tf_addr_seq #(.LOGN(4), .LANES(2)) u1 (
      .clk              (clk),
      .rst              (rst),
      .start            (start1),
      .mode             (mode),
      .busy             (busy1),
      .done             (done1),
      .tf_valid         (valid1),
      .tf_ready         (tf_ready),
      .tf_addr          (addr1),
      .tf_stage         (stg1),
      .tf_last_in_stage (last1)
   );

   int checks   = 0;
   int failures = 0;

   bit m_busy[2];
   bit m_done[2];
   bit m_mode[2];
   int m_pos[2];

   int log0[$];
   int log1[$];
   int stglog0[$];
   int lastlog0[$];
   int nbeats[2];

   int ntt_exp[32] = '{0,0,0,0,0,0,0,0, 1,1,1,1,2,2,2,2,
                       3,3,4,4,5,5,6,6, 7,8,9,10,11,12,13,14};
   int intt_exp[32] = '{14,13,12,11,10,9,8,7, 6,6,5,5,4,4,3,3,
                        2,2,2,2,1,1,1,1, 0,0,0,0,0,0,0,0};

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Expected beat idx for an N=16 transform, straight from the
   // stage/butterfly/twiddle-index arithmetic.
   function automatic void beat(input int lanes, input bit m,
                                input int idx, output int a,
                                output int st, output bit lst);
      int nb;
      int si;
      int c;
      int base;
      int b;
      int k;
      nb   = 8 / lanes;
      si   = idx / nb;
      c    = idx % nb;
      st   = m ? 3 - si : si;
      base = (1 << st) - 1;
      a    = 0;
      for (int l = 0; l < lanes; l++) begin
         b = c * lanes + l;
         k = b >> (3 - st);
         a = a | ((m ? 2 * base - k : base + k) << (4 * l));
      end
      lst = (c == nb - 1);
   endfunction

   task automatic mon(input int id, input bit busy, input bit done,
                      input bit valid, input int addr, input int stg,
                      input bit last, input bit st);
      int lanes;
      int total;
      int ea;
      int es;
      bit el;
      bit was_done;
      lanes = (id != 0) ? 2 : 1;
      total = 4 * (8 / lanes);
      chk($sformatf("busy%0d", id), busy, m_busy[id]);
      chk($sformatf("done%0d", id), done, m_done[id]);
      chk($sformatf("valid%0d", id), valid, m_busy[id]);
      if (m_busy[id]) begin
         beat(lanes, m_mode[id], m_pos[id], ea, es, el);
         chk($sformatf("addr%0d_b%0d", id, m_pos[id]), addr, ea);
         chk($sformatf("stage%0d_b%0d", id, m_pos[id]), stg, es);
         chk($sformatf("last%0d_b%0d", id, m_pos[id]), last, el);
      end
      if (valid && tf_ready && !rst) begin
         if (id == 0) begin
            log0.push_back(addr & 15);
            stglog0.push_back(stg);
            if (last) lastlog0.push_back(nbeats[0]);
         end else begin
            log1.push_back(addr & 15);
            log1.push_back((addr >> 4) & 15);
         end
         nbeats[id]++;
      end
      was_done   = m_done[id];
      m_done[id] = 1'b0;
      if (rst) begin
         m_busy[id] = 1'b0;
         m_pos[id]  = 0;
         m_mode[id] = 1'b0;
      end else if (m_busy[id]) begin
         if (tf_ready) begin
            m_pos[id]++;
            if (m_pos[id] == total) begin
               m_busy[id] = 1'b0;
               m_done[id] = 1'b1;
            end
         end
      end else if (!was_done && st) begin
         m_busy[id] = 1'b1;
         m_mode[id] = mode;
         m_pos[id]  = 0;
      end
   endtask

   always @(negedge clk) begin
      mon(0, busy0, done0, valid0, int'(addr0), int'(stg0), last0,
          start0);
      mon(1, busy1, done1, valid1, int'(addr1), int'(stg1), last1,
          start1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_wait(input bit w0, input bit w1,
                           input string name);
      bit s0;
      bit s1;
      s0 = !w0;
      s1 = !w1;
      for (int i = 0; i < 200 && !(s0 && s1); i++) begin
         tick();
         if (done0) s0 = 1'b1;
         if (done1) s1 = 1'b1;
      end
      chk({name, "_done_seen"}, int'(s0 && s1), 1);
      tick();
   endtask

   task automatic wait_beats(input int n, input string name);
      for (int i = 0; i < 100 && nbeats[0] < n; i++) tick();
      chk({name, "_reach_beat"}, nbeats[0], n);
   endtask

   task automatic cmp_log(input string name, input int q[$],
                          input int exp[32]);
      chk({name, "_len"}, q.size(), 32);
      for (int i = 0; i < 32 && i < q.size(); i++)
         chk($sformatf("%s_%0d", name, i), q[i], exp[i]);
   endtask

   task automatic clear_logs();
      log0.delete();
      log1.delete();
      stglog0.delete();
      lastlog0.delete();
      nbeats[0] = 0;
      nbeats[1] = 0;
   endtask

   initial begin
      rst      = 1'b1;
      start0   = 1'b0;
      start1   = 1'b0;
      mode     = 1'b0;
      tf_ready = 1'b1;
      tick();
      tick();
      chk("rst_valid", valid0, 0);
      chk("rst_busy", busy0, 0);
      chk("rst_done", done0, 0);
      chk("rst_addr0", addr0, 0);
      chk("rst_addr1", addr1, 0);
      chk("rst_stage", stg0, 0);
      chk("rst_last", last0, 0);
      rst = 1'b0;
      tick();

      // NTT, one and two lanes together
      clear_logs();
      start0 = 1'b1;
      start1 = 1'b1;
      tick();
      start0 = 1'b0;
      start1 = 1'b0;
      chk("ntt_first_valid", valid0, 1);
      chk("ntt_first_busy", busy0, 1);
      chk("ntt_first_addr", addr0, 0);
      run_wait(1, 1, "ntt");
      cmp_log("ntt_l1", log0, ntt_exp);
      cmp_log("ntt_l2", log1, ntt_exp);
      chk("ntt_l1_beats", nbeats[0], 32);
      chk("ntt_l2_beats", nbeats[1], 16);
      chk("ntt_last_cnt", lastlog0.size(), 4);
      for (int i = 0; i < 4 && i < lastlog0.size(); i++)
         chk($sformatf("ntt_last_pos%0d", i), lastlog0[i], 8 * i + 7);

      // INTT, one lane
      clear_logs();
      mode   = 1'b1;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      mode   = 1'b0;
      run_wait(1, 0, "intt");
      cmp_log("intt", log0, intt_exp);
      if (stglog0.size() == 32)
         for (int i = 0; i < 4; i++)
            chk($sformatf("intt_stage%0d", i), stglog0[8 * i], 3 - i);
      else
         chk("intt_stage_len", stglog0.size(), 32);

      // Backpressure in stage 2
      clear_logs();
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      wait_beats(18, "bp");
      tf_ready = 1'b0;
      begin
         int a;
         int s;
         a = int'(addr0);
         s = int'(stg0);
         chk("bp_stage_is_2", s, 2);
         for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("bp_hold_addr%0d", i), addr0, a);
            chk($sformatf("bp_hold_valid%0d", i), valid0, 1);
         end
      end
      tf_ready = 1'b1;
      run_wait(1, 0, "bp");
      cmp_log("bp", log0, ntt_exp);

      // Start (with INTT mode) while busy is ignored
      clear_logs();
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      start0 = 1'b1;
      mode   = 1'b1;
      tick();
      start0 = 1'b0;
      mode   = 1'b0;
      run_wait(1, 0, "restart");
      cmp_log("restart", log0, ntt_exp);

      // Reset mid-run, then a fresh full run
      clear_logs();
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      wait_beats(10, "midrst");
      rst = 1'b1;
      tick();
      chk("midrst_valid", valid0, 0);
      chk("midrst_busy", busy0, 0);
      chk("midrst_done", done0, 0);
      chk("midrst_addr", addr0, 0);
      chk("midrst_stage", stg0, 0);
      chk("midrst_last", last0, 0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("midrst_nodone%0d", i), done0, 0);
      end
      clear_logs();
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      run_wait(1, 0, "after_rst");
      cmp_log("after_rst", log0, ntt_exp);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
